ram_lcu_column_ctrl: RTL and testbench

//  Controller for the 32x64 dual-port LCU left-column RAM used by intra prediction.

---
 rtl/ram_lcu_column_ctrl.sv | 147 ++++++++++++++
 tb/tb_ram_lcu_column_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lcu_column_ctrl.sv
// rtl/ram_lcu_column_ctrl.sv - LCU left-column RAM controller: clear, writeback on port A, burst reads on port B
module ram_lcu_column_ctrl #(
   parameter int                WORD_W   = 32,
   parameter int                ADDR_W   = 6,
   parameter logic [WORD_W-1:0] INIT_VAL = 32'h80808080
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              lcu_start_i,
   output logic              init_done_o,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WORD_W-1:0] wr_data_i,
   output logic              wr_ack_o,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [ADDR_W:0]   rd_len_i,
   output logic              rd_ack_o,
   output logic              rd_busy_o,
   output logic              rd_valid_o,
   output logic [WORD_W-1:0] rd_data_o,
   output logic              ram_cena_o,
   output logic              ram_wena_o,
   output logic [ADDR_W-1:0] ram_addra_o,
   output logic [WORD_W-1:0] ram_dataa_o,
   output logic              ram_oena_o,
   output logic              ram_cenb_o,
   output logic              ram_wenb_o,
   output logic [ADDR_W-1:0] ram_addrb_o,
   output logic [WORD_W-1:0] ram_datab_o,
   output logic              ram_oenb_o,
   input  logic [WORD_W-1:0] ram_datab_i
);

   localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(1 << ADDR_W);
   localparam logic [ADDR_W-2:0] CLR_LAST = '1;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t            state;
   logic [ADDR_W-2:0] clr_cnt;
   logic [ADDR_W:0]   rd_rem;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              rd_valid_q;
   logic              byp_q;
   logic [WORD_W-1:0] byp_data_q;
   logic [WORD_W-1:0] data_hold_q;

   logic              serve;
   logic              busy;
   logic              issue;
   logic [ADDR_W:0]   len_sat;
   logic [ADDR_W-1:0] issue_addr;

   // normal service only in IDLE and never in the cycle a new LCU starts
   assign serve      = (state == ST_IDLE) & ~lcu_start_i;
   assign busy       = (rd_rem != '0);
   assign wr_ack_o   = serve & wr_req_i;
   assign rd_ack_o   = serve & rd_req_i & ~busy;
   assign len_sat    = (rd_len_i > MAX_LEN) ? MAX_LEN : rd_len_i;
   assign issue      = serve & (busy | (rd_ack_o & (len_sat != '0)));
   assign issue_addr = busy ? rd_addr_q : rd_addr_i;

   assign rd_busy_o  = busy;
   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_valid_q ? (byp_q ? byp_data_q : ram_datab_i) : data_hold_q;
   assign ram_oena_o = 1'b0;
   assign ram_oenb_o = 1'b0;

   always_comb begin
      ram_cena_o  = 1'b1;
      ram_wena_o  = 1'b1;
      ram_addra_o = '0;
      ram_dataa_o = '0;
      ram_cenb_o  = 1'b1;
      ram_wenb_o  = 1'b1;
      ram_addrb_o = '0;
      ram_datab_o = '0;
      if (state == ST_CLEAR) begin
         ram_cena_o  = 1'b0;
         ram_wena_o  = 1'b0;
         ram_addra_o = {clr_cnt, 1'b0};
         ram_dataa_o = INIT_VAL;
         ram_cenb_o  = 1'b0;
         ram_wenb_o  = 1'b0;
         ram_addrb_o = {clr_cnt, 1'b1};
         ram_datab_o = INIT_VAL;
      end else begin
         if (wr_ack_o) begin
            ram_cena_o  = 1'b0;
            ram_wena_o  = 1'b0;
            ram_addra_o = wr_addr_i;
            ram_dataa_o = wr_data_i;
         end
         if (issue) begin
            ram_cenb_o  = 1'b0;
            ram_addrb_o = issue_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         clr_cnt     <= '0;
         init_done_o <= 1'b0;
         rd_rem      <= '0;
         rd_addr_q   <= '0;
         rd_valid_q  <= 1'b0;
         byp_q       <= 1'b0;
         byp_data_q  <= '0;
         data_hold_q <= '0;
      end else begin
         init_done_o <= 1'b0;
         if (lcu_start_i) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
         end else if (state == ST_CLEAR) begin
            if (clr_cnt == CLR_LAST) begin
               state       <= ST_IDLE;
               init_done_o <= 1'b1;
            end else begin
               clr_cnt <= clr_cnt + (ADDR_W-1)'(1);
            end
         end

         if (lcu_start_i) begin
            rd_rem <= '0;
         end else if (rd_ack_o) begin
            rd_rem    <= (len_sat == '0) ? '0 : len_sat - (ADDR_W+1)'(1);
            rd_addr_q <= rd_addr_i + ADDR_W'(1);
         end else if (busy) begin
            rd_rem    <= rd_rem - (ADDR_W+1)'(1);
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
         end

         // the RAM returns the old word on a same-address read/write, so forward the new one
         rd_valid_q <= issue;
         byp_q      <= issue & wr_ack_o & (issue_addr == wr_addr_i);
         if (issue & wr_ack_o & (issue_addr == wr_addr_i))
            byp_data_q <= wr_data_i;
         if (rd_valid_q)
            data_hold_q <= rd_data_o;
      end
   end

endmodule

// File: tb/tb_ram_lcu_column_ctrl.sv
// tb/tb_ram_lcu_column_ctrl.sv - self-checking bench for ram_lcu_column_ctrl
module tb_ram_lcu_column_ctrl;

   localparam logic [31:0] IV = 32'h80808080;

   logic        clk = 1'b0;
   logic        rstn;
   logic        lcu_start_i, init_done_o;
   logic        wr_req_i, wr_ack_o;
   logic [5:0]  wr_addr_i;
   logic [31:0] wr_data_i;
   logic        rd_req_i, rd_ack_o, rd_busy_o, rd_valid_o;
   logic [5:0]  rd_addr_i;
   logic [6:0]  rd_len_i;
   logic [31:0] rd_data_o;
   logic        ram_cena_o, ram_wena_o, ram_oena_o, ram_cenb_o, ram_wenb_o, ram_oenb_o;
   logic [5:0]  ram_addra_o, ram_addrb_o;
   logic [31:0] ram_dataa_o, ram_datab_o, ram_datab_i;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   ram_lcu_column_ctrl dut (
      .clk(clk), .rstn(rstn), .lcu_start_i(lcu_start_i), .init_done_o(init_done_o),
      .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_ack_o(wr_ack_o),
      .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_len_i(rd_len_i), .rd_ack_o(rd_ack_o),
      .rd_busy_o(rd_busy_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
      .ram_cena_o(ram_cena_o), .ram_wena_o(ram_wena_o), .ram_addra_o(ram_addra_o),
      .ram_dataa_o(ram_dataa_o), .ram_oena_o(ram_oena_o),
      .ram_cenb_o(ram_cenb_o), .ram_wenb_o(ram_wenb_o), .ram_addrb_o(ram_addrb_o),
      .ram_datab_o(ram_datab_o), .ram_oenb_o(ram_oenb_o), .ram_datab_i(ram_datab_i)
   );

   // dual-port RAM: synchronous write, 1-cycle read latency, read-before-write on collision
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (!ram_cena_o && !ram_wena_o) mem[ram_addra_o] <= ram_dataa_o;
      if (!ram_cenb_o && !ram_wenb_o) mem[ram_addrb_o] <= ram_datab_o;
      if (!ram_cenb_o && ram_wenb_o) ram_datab_i <= mem[ram_addrb_o];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: memory image plus burst bookkeeping in cycle numbers
   logic [31:0] ref_mem [64];
   int          m_cyc, m_t0, m_len, m_base;
   bit          m_active, m_pend_valid;
   logic [31:0] m_pend_data, m_last;

   task automatic model_reset(input logic [31:0] last);
      foreach (ref_mem[i]) ref_mem[i] = IV;
      m_cyc = 0; m_t0 = 0; m_len = 0; m_base = 0;
      m_active = 0; m_pend_valid = 0; m_pend_data = '0; m_last = last;
   endtask

   task automatic step(input logic wq, input logic [5:0] wa, input logic [31:0] wd,
                       input logic rq, input logic [5:0] ra, input logic [6:0] rl);
      bit          e_busy, e_rack, e_valid, issue_e;
      logic [31:0] e_data;
      logic [5:0]  ia;
      @(posedge clk); #1;
      lcu_start_i = 1'b0;
      wr_req_i = wq; wr_addr_i = wa; wr_data_i = wd;
      rd_req_i = rq; rd_addr_i = ra; rd_len_i = rl;
      m_cyc++;
      e_valid = m_pend_valid;
      if (m_pend_valid) m_last = m_pend_data;
      e_data = m_last;
      e_busy = m_active && (m_cyc > m_t0) && (m_cyc < m_t0 + m_len);
      e_rack = rq && !e_busy;
      if (wq) ref_mem[wa] = wd;
      if (e_rack) begin
         m_t0 = m_cyc; m_len = (rl > 7'd64) ? 64 : int'(rl); m_base = int'(ra); m_active = 1;
      end
      issue_e = m_active && (m_cyc >= m_t0) && (m_cyc < m_t0 + m_len);
      m_pend_valid = issue_e;
      if (issue_e) begin
         ia = 6'((m_base + m_cyc - m_t0) % 64);
         m_pend_data = ref_mem[ia];
      end
      @(negedge clk);
      chk("m_wr_ack", wr_ack_o, wq);
      chk("m_rd_ack", rd_ack_o, e_rack);
      chk("m_rd_busy", rd_busy_o, e_busy);
      chk("m_rd_valid", rd_valid_o, e_valid);
      chk("m_rd_data", rd_data_o, e_data);
   endtask

   task automatic drive_idle();
      lcu_start_i = 1'b0; wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
      rd_req_i = 1'b0; rd_addr_i = '0; rd_len_i = '0;
   endtask

   // pulse lcu_start_i and follow the whole clear, requests held high to prove nothing is granted
   task automatic do_clear(input bit mid_burst, input logic [31:0] held);
      int done_at = -1;
      int n_done = 0, bad_ack = 0, bad_rd = 0, bad_port = 0;
      logic [5:0] ea;
      for (int k = 0; k <= 40; k++) begin
         @(posedge clk); #1;
         lcu_start_i = (k == 0);
         wr_req_i = (k <= 32); wr_addr_i = 6'(k); wr_data_i = $urandom;
         rd_req_i = (k <= 32); rd_addr_i = 6'(k); rd_len_i = 7'd5;
         @(negedge clk);
         if (k <= 32 && (wr_ack_o || rd_ack_o)) bad_ack++;
         if (k >= 1 && (rd_valid_o || rd_busy_o)) bad_rd++;
         if (k >= 1 && k <= 32) begin
            ea = 6'(2 * (k - 1));
            if (ram_cena_o || ram_wena_o || ram_addra_o != ea || ram_dataa_o != IV ||
                ram_cenb_o || ram_wenb_o || ram_addrb_o != (ea | 6'd1) || ram_datab_o != IV)
               bad_port++;
         end
         if (init_done_o) begin
            n_done++;
            if (done_at < 0) done_at = k;
         end
         if (k == 0 && mid_burst) begin
            chk("abort_beat2_valid", rd_valid_o, 1'b1);
            chk("abort_beat2_data", rd_data_o, held);
         end
      end
      drive_idle();
      chk("clear_no_grants", bad_ack, 0);
      chk("clear_no_read", bad_rd, 0);
      chk("clear_ports", bad_port, 0);
      chk("init_done_cycle", done_at, 33);
      chk("init_done_pulses", n_done, 1);
   endtask

   typedef struct {
      logic        wq;
      logic [5:0]  wa;
      logic [31:0] wd;
      logic        rq;
      logic [5:0]  ra;
      logic [6:0]  rl;
      logic        e_wack, e_rack, e_busy, e_valid;
      logic [31:0] e_data;
   } vec_t;

   vec_t tbl [15];

   initial begin
      tbl[0]  = '{1'b1, 6'd5,  32'h11223344, 1'b0, 6'd0,  7'd0, 1'b1, 1'b0, 1'b0, 1'b0, IV};
      tbl[1]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd4,  7'd3, 1'b0, 1'b1, 1'b0, 1'b0, IV};
      tbl[2]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  7'd0, 1'b0, 1'b0, 1'b1, 1'b1, IV};
      tbl[3]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  7'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11223344};
      tbl[4]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  7'd0, 1'b0, 1'b0, 1'b0, 1'b1, IV};
      tbl[5]  = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd62, 7'd4, 1'b0, 1'b1, 1'b0, 1'b0, IV};
      tbl[6]  = '{1'b1, 6'd1,  32'h01010101, 1'b1, 6'd7,  7'd5, 1'b1, 1'b0, 1'b1, 1'b1, IV};
      tbl[7]  = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  7'd0, 1'b0, 1'b0, 1'b1, 1'b1, IV};
      tbl[8]  = '{1'b1, 6'd0,  32'h0000AAAA, 1'b0, 6'd0,  7'd0, 1'b1, 1'b0, 1'b1, 1'b1, IV};
      tbl[9]  = '{1'b1, 6'd10, 32'hDEADBEEF, 1'b1, 6'd10, 7'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h01010101};
      tbl[10] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
      tbl[11] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd3,  7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
      tbl[12] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd3,  7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
      tbl[13] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd0,  7'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
      tbl[14] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000AAAA};

      rstn = 1'b0;
      drive_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_init_done", init_done_o, 1'b0);
      chk("rst_rd_valid", rd_valid_o, 1'b0);
      chk("rst_rd_busy", rd_busy_o, 1'b0);
      chk("rst_rd_data", rd_data_o, 32'h0);
      chk("rst_ram_cena", ram_cena_o, 1'b1);
      chk("rst_ram_wena", ram_wena_o, 1'b1);
      chk("rst_ram_cenb", ram_cenb_o, 1'b1);
      chk("rst_ram_wenb", ram_wenb_o, 1'b1);
      @(posedge clk); #1;
      rstn = 1'b1;

      do_clear(1'b0, 32'h0);
      model_reset(32'h0);
      step(1'b0, 6'd0, 32'h0, 1'b1, 6'd0, 7'd64);
      repeat (66) step(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 7'd0);

      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         wr_req_i = tbl[i].wq; wr_addr_i = tbl[i].wa; wr_data_i = tbl[i].wd;
         rd_req_i = tbl[i].rq; rd_addr_i = tbl[i].ra; rd_len_i = tbl[i].rl;
         @(negedge clk);
         chk($sformatf("vec%0d_wr_ack", i), wr_ack_o, tbl[i].e_wack);
         chk($sformatf("vec%0d_rd_ack", i), rd_ack_o, tbl[i].e_rack);
         chk($sformatf("vec%0d_rd_busy", i), rd_busy_o, tbl[i].e_busy);
         chk($sformatf("vec%0d_rd_valid", i), rd_valid_o, tbl[i].e_valid);
         chk($sformatf("vec%0d_rd_data", i), rd_data_o, tbl[i].e_data);
      end

      // abort an 8-beat burst while its second beat is on the bus
      @(posedge clk); #1;
      drive_idle();
      rd_req_i = 1'b1; rd_addr_i = 6'd20; rd_len_i = 7'd8;
      @(negedge clk);
      chk("abort_accept", rd_ack_o, 1'b1);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("abort_beat1_valid", rd_valid_o, 1'b1);
      chk("abort_beat1_data", rd_data_o, IV);
      chk("abort_beat1_busy", rd_busy_o, 1'b1);
      do_clear(1'b1, IV);

      model_reset(IV);
      step(1'b0, 6'd0, 32'h0, 1'b1, 6'd37, 7'd64);
      repeat (66) step(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 7'd0);

      for (int i = 0; i < 1500; i++) begin
         logic       wq, rq;
         logic [5:0] wa, ra;
         logic [6:0] rl;
         int         sel;
         wq  = ($urandom_range(0, 1) == 1);
         rq  = ($urandom_range(0, 9) < 4);
         wa  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
         ra  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
         sel = $urandom_range(0, 15);
         if (sel == 0)      rl = 7'd0;
         else if (sel == 1) rl = 7'($urandom_range(65, 127));
         else if (sel == 2) rl = 7'd64;
         else               rl = 7'($urandom_range(1, 10));
         step(wq, wa, $urandom, rq, ra, rl);
      end
      repeat (70) step(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 7'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
